or_vector_checker: RTL and testbench



---
 rtl/or_vector_checker.sv | 135 +++++++++++++
 tb/tb_or_vector_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/or_vector_checker.sv
// Clocked stimulus/check stage for NUM_DUT two-input OR implementations: walks a,b through 00,01,10,11 and scores y_in.
// Latency: done rises 4*(SETTLE_CYCLES+1) edges after the start-accept edge.
// Backpressure: none; start is accepted only in IDLE/DONE and ignored while busy.
module or_vector_checker #(
    parameter int NUM_DUT       = 3,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               a,
    output logic               b,
    input  logic [NUM_DUT-1:0] y_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   fail_count,
    output logic [NUM_DUT-1:0] fail_mask,
    output logic [1:0]         pattern_idx
);

    localparam int PC_W  = $clog2(NUM_DUT + 1);
    localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SC_W-1:0]  SETTLE_RELOAD = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [SUM_W-1:0] CNT_MAX       = SUM_W'({CNT_W{1'b1}});

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

    state_e             state_q, state_d;
    logic [1:0]         pat_q, pat_d;
    logic [SC_W-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;
    logic [NUM_DUT-1:0] mask_q, mask_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic               accept;
    logic               expected;
    logic [NUM_DUT-1:0] mismatch;
    logic [PC_W-1:0]    popcnt;
    logic [SUM_W-1:0]   sum;
    logic [CNT_W-1:0]   fcnt_sat;

    assign accept   = start && (state_q == IDLE || state_q == DONE);
    assign expected = |pat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pat_q    <= 2'd0;
            settle_q <= '0;
            fcnt_q   <= '0;
            mask_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            settle_q <= settle_d;
            fcnt_q   <= fcnt_d;
            mask_q   <= mask_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = SETTLE;
            SETTLE:     if (settle_q == '0) state_d = SAMPLE;
            SAMPLE:     state_d = (pat_q == 2'd3) ? DONE : SETTLE;
            default:    state_d = IDLE;
        endcase
    end

    // An X on y_in must score as a failure, hence the case inequality.
    always_comb begin
        mismatch = '0;
        popcnt   = '0;
        for (int i = 0; i < NUM_DUT; i++) begin
            mismatch[i] = (y_in[i] !== expected);
            popcnt      = popcnt + PC_W'(mismatch[i]);
        end
        sum      = SUM_W'(fcnt_q) + SUM_W'(popcnt);
        fcnt_sat = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_comb begin
        pat_d    = pat_q;
        settle_d = settle_q;
        fcnt_d   = fcnt_q;
        mask_d   = mask_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        if (accept) begin
            pat_d    = 2'd0;
            settle_d = SETTLE_RELOAD;
            fcnt_d   = '0;
            mask_d   = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            pass_d   = 1'b0;
        end else if (state_q == SETTLE) begin
            if (settle_q != '0) settle_d = settle_q - 1'b1;
        end else if (state_q == SAMPLE) begin
            mask_d = mask_q | mismatch;
            fcnt_d = fcnt_sat;
            if (pat_q == 2'd3) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = (fcnt_sat == '0);
            end else begin
                pat_d    = pat_q + 2'd1;
                settle_d = SETTLE_RELOAD;
            end
        end
    end

    assign a           = pat_q[1];
    assign b           = pat_q[0];
    assign pattern_idx = pat_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_count  = fcnt_q;
    assign fail_mask   = mask_q;

endmodule

// File: tb/tb_or_vector_checker.sv
// Bench for or_vector_checker: three instances (default, SETTLE_CYCLES=3, CNT_W=2) against a time-based model.
module tb_or_vector_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [2:0] start = 3'b000;
    logic [1:0] mode [3];
    bit chk_en = 1'b0;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    wire [2:0]      a_v, b_v, busy_v, done_v, pass_v;
    wire [2:0][2:0] y_v, mask_v;
    wire [2:0][1:0] pat_v;
    wire [2:0][7:0] fc_v;
    wire [1:0]      fc2;
    logic [2:0]     ord1, ord2;

    assign fc_v[2] = {6'd0, fc2};

    // Emulated OR implementations: 0 correct, 1 DUT1 stuck-at-0, 2 all inverted, 3 lag two cycles.
    function automatic logic [2:0] gen_y(input logic [1:0] m, input logic orv, input logic lag);
        case (m)
            2'd0:    gen_y = {3{orv}};
            2'd1:    gen_y = {orv, 1'b0, orv};
            2'd2:    gen_y = {3{~orv}};
            default: gen_y = {3{lag}};
        endcase
    endfunction

    always @(posedge clk) begin
        ord1 <= a_v | b_v;
        ord2 <= ord1;
    end

    assign y_v[0] = gen_y(mode[0], a_v[0] | b_v[0], ord2[0]);
    assign y_v[1] = gen_y(mode[1], a_v[1] | b_v[1], ord2[1]);
    assign y_v[2] = gen_y(mode[2], a_v[2] | b_v[2], ord2[2]);

    or_vector_checker u_def (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a_v[0]), .b(b_v[0]), .y_in(y_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .fail_count(fc_v[0]),
        .fail_mask(mask_v[0]), .pattern_idx(pat_v[0])
    );

    or_vector_checker #(.SETTLE_CYCLES(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a_v[1]), .b(b_v[1]), .y_in(y_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .fail_count(fc_v[1]),
        .fail_mask(mask_v[1]), .pattern_idx(pat_v[1])
    );

    or_vector_checker #(.CNT_W(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .a(a_v[2]), .b(b_v[2]), .y_in(y_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .fail_count(fc2),
        .fail_mask(mask_v[2]), .pattern_idx(pat_v[2])
    );

    function automatic int s_of(input int j);
        return (j == 1) ? 3 : 1;
    endfunction

    function automatic int max_of(input int j);
        return (j == 2) ? 3 : 255;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: a run is 4 patterns of (S+1) edges each; the last edge of each pattern scores y_in.
    bit         m_run [3];
    bit         m_done[3];
    bit         m_pass[3];
    int         m_k   [3];
    int         m_fc  [3];
    logic [2:0] m_mask[3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 3; j++) begin
                m_run[j] = 0; m_done[j] = 0; m_pass[j] = 0;
                m_k[j] = 0; m_fc[j] = 0; m_mask[j] = 3'b000;
            end
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (!m_run[j]) begin
                    if (start[j]) begin
                        m_run[j] = 1; m_done[j] = 0; m_pass[j] = 0;
                        m_k[j] = 0; m_fc[j] = 0; m_mask[j] = 3'b000;
                    end
                end else begin
                    if ((m_k[j] % (s_of(j) + 1)) == s_of(j)) begin
                        for (int i = 0; i < 3; i++) begin
                            if (y_v[j][i] !== ((m_k[j] / (s_of(j) + 1)) != 0)) begin
                                if (m_fc[j] < max_of(j)) m_fc[j]++;
                                m_mask[j][i] = 1'b1;
                            end
                        end
                    end
                    m_k[j]++;
                    if (m_k[j] == 4 * (s_of(j) + 1)) begin
                        m_run[j] = 0; m_done[j] = 1; m_pass[j] = (m_fc[j] == 0);
                    end
                end
            end
        end
    end

    int ep;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < 3; j++) begin
                ep = m_run[j] ? m_k[j] / (s_of(j) + 1) : (m_done[j] ? 3 : 0);
                chk($sformatf("u%0d busy", j), busy_v[j], m_run[j]);
                chk($sformatf("u%0d done", j), done_v[j], m_done[j]);
                chk($sformatf("u%0d pass", j), pass_v[j], m_pass[j]);
                chk($sformatf("u%0d pattern", j), pat_v[j], ep);
                chk($sformatf("u%0d a", j), a_v[j], ep / 2);
                chk($sformatf("u%0d b", j), b_v[j], ep % 2);
                chk($sformatf("u%0d fail_count", j), fc_v[j], m_fc[j]);
                chk($sformatf("u%0d fail_mask", j), mask_v[j], m_mask[j]);
            end
        end
    end

    task automatic run_inst(input int j, input bit mid_pulse, output int edges, output logic [15:0] seq);
        seq = 16'h0000;
        @(negedge clk); start[j] = 1'b1;
        @(negedge clk); start[j] = 1'b0;
        edges = 0;
        while (!done_v[j] && edges < 100) begin
            if (edges < 8) seq = {seq[13:0], pat_v[j]};
            @(negedge clk);
            edges++;
            start[j] = mid_pulse && (edges == 5);
        end
    endtask

    int          edges;
    logic [15:0] seq;

    initial begin
        mode[0] = 2'd0; mode[1] = 2'd3; mode[2] = 2'd2;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", busy_v, 3'b000);
        chk("reset done", done_v, 3'b000);
        chk("reset ab", {a_v, b_v}, 6'd0);
        chk("reset fail_count", fc_v, 24'd0);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Clean run, default settle.
        run_inst(0, 1'b0, edges, seq);
        chk("clean done edge", edges, 8);
        chk("clean ab sequence", seq, 16'h05AF);
        chk("clean pass", pass_v[0], 1);
        chk("clean fail_count", fc_v[0], 0);

        // DUT1 stuck at 0, restarted straight from DONE.
        mode[0] = 2'd1;
        run_inst(0, 1'b0, edges, seq);
        chk("stuck done edge", edges, 8);
        chk("stuck fail_count", fc_v[0], 3);
        chk("stuck fail_mask", mask_v[0], 3'b010);
        chk("stuck pass", pass_v[0], 0);

        // A second start mid-run must not extend or clear the run.
        run_inst(0, 1'b1, edges, seq);
        chk("midstart done edge", edges, 8);
        chk("midstart fail_count", fc_v[0], 3);

        // Reset during SETTLE of pattern 10, then a fresh clean run.
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset pattern", pat_v[0], 2);
        chk("pre-reset fail_count", fc_v[0], 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset busy", busy_v[0], 0);
        chk("async reset pattern", pat_v[0], 0);
        chk("async reset fail_count", fc_v[0], 0);
        chk("async reset fail_mask", mask_v[0], 0);
        @(negedge clk); #1 rst_n = 1'b1;
        mode[0] = 2'd0;
        run_inst(0, 1'b0, edges, seq);
        chk("post-reset done edge", edges, 8);
        chk("post-reset pass", pass_v[0], 1);

        // SETTLE_CYCLES=3 with a DUT that lags two cycles.
        run_inst(1, 1'b0, edges, seq);
        chk("settle3 done edge", edges, 16);
        chk("settle3 pass", pass_v[1], 1);
        chk("settle3 fail_count", fc_v[1], 0);

        // CNT_W=2, all inverted: 12 mismatches saturate at 3.
        run_inst(2, 1'b0, edges, seq);
        chk("sat done edge", edges, 8);
        chk("sat fail_count", fc_v[2], 3);
        chk("sat fail_mask", mask_v[2], 3'b111);
        chk("sat pass", pass_v[2], 0);
        @(negedge clk); start[2] = 1'b1;
        @(posedge clk); #1;
        chk("restart fail_count", fc_v[2], 0);
        chk("restart fail_mask", mask_v[2], 0);
        chk("restart done", done_v[2], 0);
        chk("restart busy", busy_v[2], 1);
        @(negedge clk); start[2] = 1'b0;
        edges = 0;
        while (!done_v[2] && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        chk("restart completes", edges < 100, 1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
